// File: rtl/bus_sequencer_pkg.sv
// Shared types for the master-bus sequencer: unit IDs, bus commands, FSM states and the move request.
package bus_sequencer_pkg;

    typedef logic [3:0]  unit_id_t;
    typedef logic [3:0]  bus_cmd_t;
    typedef logic [15:0] word_t;

    // ID 0 selects no unit on the bus.
    localparam unit_id_t UNIT_NONE = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } seq_state_t;

    typedef struct packed {
        unit_id_t src;
        unit_id_t dst;
        bus_cmd_t rcmd;
        bus_cmd_t wcmd;
    } bus_req_t;

endpackage

// File: rtl/bus_sequencer_req_fifo.sv
// Synchronous request FIFO; one extra pointer bit tells full from empty after wrap.
// Push is dropped while full, even when a pop occurs in the same cycle.
module req_fifo
    import bus_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  bus_req_t push_req,
    input  logic     pop,
    output bus_req_t head,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    bus_req_t    mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_req;
        end
    end

endmodule

// File: rtl/bus_sequencer.sv
// Master-bus sequencer: each queued move reads a word from the source unit, then writes it to the destination.
// Optional READ timeout abort is compiled in with BUS_SEQUENCER_TIMEOUT_EN.
module bus_sequencer
    import bus_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [3:0]            i_req_src,
    input  logic [3:0]            i_req_dst,
    input  logic [3:0]            i_req_rcmd,
    input  logic [3:0]            i_req_wcmd,
    output logic [3:0]            o_read_id,
    output logic [3:0]            o_read_command,
    output logic [3:0]            o_write_id,
    output logic [3:0]            o_write_command,
    output logic [DATA_WIDTH-1:0] o_bus_data,
    output logic                  o_bus_valid,
    input  logic [DATA_WIDTH-1:0] i_bus_data,
    input  logic                  i_bus_valid,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_busy
);
    if (DATA_WIDTH != $bits(word_t)) begin : g_bad_width
        $error("bus_sequencer: DATA_WIDTH must equal the bus word width");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bus_sequencer: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("bus_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_t state;
    bus_req_t   new_req;
    bus_req_t   head;
    unit_id_t   req_dst;
    bus_cmd_t   req_wcmd;
    logic       full;
    logic       empty;
    logic       pop;

    assign new_req     = '{src: i_req_src, dst: i_req_dst, rcmd: i_req_rcmd, wcmd: i_req_wcmd};
    assign pop         = (state == IDLE) && !empty;
    assign o_req_ready = !full;
    assign o_busy      = !empty || (state != IDLE);

    req_fifo #(.DEPTH(FIFO_DEPTH)) u_req_fifo (
        .clk      (i_clk),
        .rst      (i_reset),
        .push     (i_req_valid),
        .push_req (new_req),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

`ifdef BUS_SEQUENCER_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign o_error = 1'b0;
`endif

    // Bus outputs are registered so each phase drives clean fields for its whole cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            req_dst         <= UNIT_NONE;
            req_wcmd        <= '0;
            o_read_id       <= UNIT_NONE;
            o_read_command  <= '0;
            o_write_id      <= UNIT_NONE;
            o_write_command <= '0;
            o_bus_data      <= '0;
            o_bus_valid     <= 1'b0;
            o_done          <= 1'b0;
`ifdef BUS_SEQUENCER_TIMEOUT_EN
            o_error         <= 1'b0;
            tmo_cnt         <= '0;
`endif
        end else begin
            o_done <= 1'b0;
`ifdef BUS_SEQUENCER_TIMEOUT_EN
            o_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state          <= READ;
                        req_dst        <= head.dst;
                        req_wcmd       <= head.wcmd;
                        o_read_id      <= head.src;
                        o_read_command <= head.rcmd;
`ifdef BUS_SEQUENCER_TIMEOUT_EN
                        tmo_cnt        <= '0;
`endif
                    end
                end
                READ: begin
                    // Returned data wins over a timeout landing in the same cycle.
                    if (i_bus_valid) begin
                        state           <= WRITE;
                        o_read_id       <= UNIT_NONE;
                        o_read_command  <= '0;
                        o_write_id      <= req_dst;
                        o_write_command <= req_wcmd;
                        o_bus_data      <= i_bus_data;
                        o_bus_valid     <= (req_dst != UNIT_NONE);
                        o_done          <= 1'b1;
                    end
`ifdef BUS_SEQUENCER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state          <= IDLE;
                        o_read_id      <= UNIT_NONE;
                        o_read_command <= '0;
                        o_error        <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                WRITE: begin
                    state           <= IDLE;
                    o_write_id      <= UNIT_NONE;
                    o_write_command <= '0;
                    o_bus_data      <= '0;
                    o_bus_valid     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer; timeout scenario runs only when BUS_SEQUENCER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_bus_sequencer;
    import bus_sequencer_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_src, req_dst, req_rcmd, req_wcmd;
    logic [3:0]    read_id, read_command, write_id, write_command;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          done, error, busy;

    int            vectors = 0;
    int            miscompares = 0;
    bus_req_t      exp_q[$];
    logic [DW-1:0] exp_data;

    always #5 clk = ~clk;

    bus_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_src(req_src), .i_req_dst(req_dst), .i_req_rcmd(req_rcmd), .i_req_wcmd(req_wcmd),
        .o_read_id(read_id), .o_read_command(read_command),
        .o_write_id(write_id), .o_write_command(write_command),
        .o_bus_data(out_data), .o_bus_valid(out_valid),
        .i_bus_data(in_data), .i_bus_valid(in_valid),
        .o_done(done), .o_error(error), .o_busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bus_req_t rand_req();
        bus_req_t r;
        r.src  = 4'($urandom_range(15, 1));
        r.dst  = 4'($urandom_range(15, 0));
        r.rcmd = 4'($urandom);
        r.wcmd = 4'($urandom);
        return r;
    endfunction

    task automatic offer(input bus_req_t r);
        req_valid = 1'b1;
        req_src   = r.src;
        req_dst   = r.dst;
        req_rcmd  = r.rcmd;
        req_wcmd  = r.wcmd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({read_id, read_command, write_id, write_command, out_data, out_valid, done, error, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rd=%h/%h wr=%h/%h data=%h v=%b done=%b err=%b busy=%b, all required 0",
                     read_id, read_command, write_id, write_command, out_data, out_valid, done, error, busy);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b busy=%b, required 1/0", req_ready, busy);
        end
    endtask

    task automatic test_single();
        bus_req_t r = '{src: 4'd3, dst: 4'd5, rcmd: 4'd2, wcmd: 4'd7};
        offer(r);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready: ready=%b, required 1", req_ready);
        end
        step();
        req_valid = 1'b0;
        vectors++;
        if (read_id !== 4'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_t1: read_id=%h busy=%b, required 0/1", read_id, busy);
        end
        step();
        vectors++;
        if ({read_id, read_command, write_id, done} !== {4'd3, 4'd2, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_read: read_id=%h rcmd=%h write_id=%h done=%b, required 3/2/0/0",
                     read_id, read_command, write_id, done);
        end
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        step();
        in_valid = 1'b0;
        vectors++;
        if ({done, write_id, write_command, out_valid, out_data, read_id} !== {1'b1, 4'd5, 4'd7, 1'b1, 16'hBEEF, 4'd0}) begin
            miscompares++;
            $display("FAIL single_write: done=%b wid=%h wcmd=%h v=%b data=%h rid=%h, required 1/5/7/1/beef/0",
                     done, write_id, write_command, out_valid, out_data, read_id);
        end
        step();
        vectors++;
        if ({done, busy, write_id, out_valid, out_data} !== '0) begin
            miscompares++;
            $display("FAIL single_after: done=%b busy=%b wid=%h v=%b data=%h, required all 0",
                     done, busy, write_id, out_valid, out_data);
        end
    endtask

    task automatic test_dst_zero();
        bus_req_t r = rand_req();
        int       n = 0;
        r.dst = 4'd0;
        offer(r);
        step();
        req_valid = 1'b0;
        while (read_id !== r.src && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (read_id !== r.src) begin
            miscompares++;
            $display("FAIL dst0_read: read_id=%h, required %h", read_id, r.src);
        end
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        exp_data = in_data;
        step();
        in_valid = 1'b0;
        vectors++;
        if ({done, out_valid, write_id, write_command, out_data} !== {1'b1, 1'b0, 4'd0, r.wcmd, exp_data}) begin
            miscompares++;
            $display("FAIL dst0_write: done=%b v=%b wid=%h wcmd=%h data=%h, required 1/0/0/%h/%h",
                     done, out_valid, write_id, write_command, out_data, r.wcmd, exp_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bus_req_t rs[5];
        bus_req_t extra = rand_req();
        bus_req_t r;
        int       got = 0, cyc = 0, last = 0, extra_done = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rs[i] = rand_req();
            offer(rs[i]);
            vectors++;
            if (req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready_push%0d: ready=%b, required 1", i, req_ready);
            end
            exp_q.push_back(rs[i]);
            step();
        end
        offer(extra);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_full%0d: ready=%b, required 0", i, req_ready);
            end
            step();
        end
        req_valid = 1'b0;
        while (got < 5 && cyc < 200) begin
            if (done === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra_done: done=1, required 0");
                end else begin
                    r = exp_q.pop_front();
                    if ({write_id, write_command, out_valid, out_data} !== {r.dst, r.wcmd, (r.dst != 4'd0), exp_data}) begin
                        miscompares++;
                        $display("FAIL b2b_order%0d: wid=%h wcmd=%h v=%b data=%h, required %h/%h/%b/%h", got,
                                 write_id, write_command, out_valid, out_data, r.dst, r.wcmd, (r.dst != 4'd0), exp_data);
                    end
                end
                if (got > 0) begin
                    vectors++;
                    if (cyc - last != 3) begin
                        miscompares++;
                        $display("FAIL b2b_spacing%0d: gap=%0d, required 3", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            in_valid = (read_id !== 4'd0);
            in_data  = DW'($urandom);
            if (in_valid) exp_data = in_data;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (got != 5) begin
            miscompares++;
            $display("FAIL b2b_timeout: completed=%0d, required 5", got);
        end
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) extra_done++;
            step();
        end
        vectors++;
        if (extra_done != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_dropped_push: extra_done=%0d busy=%b, required 0/0", extra_done, busy);
        end
        exp_q.delete();
    endtask

    task automatic test_push_pop();
        bus_req_t rs[6];
        bus_req_t r;
        int       got = 0, cyc = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) rs[i] = rand_req();
        for (int i = 0; i < 4; i++) begin
            offer(rs[i]);
            exp_q.push_back(rs[i]);
            step();
        end
        req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || read_id !== rs[0].src) begin
            miscompares++;
            $display("FAIL pp_occ3: ready=%b rid=%h, required 1/%h", req_ready, read_id, rs[0].src);
        end
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        exp_data = in_data;
        step();
        in_valid = 1'b0;
        r = exp_q.pop_front();
        vectors++;
        if ({done, write_id, write_command, out_data} !== {1'b1, r.dst, r.wcmd, exp_data}) begin
            miscompares++;
            $display("FAIL pp_first: done=%b wid=%h wcmd=%h data=%h, required 1/%h/%h/%h",
                     done, write_id, write_command, out_data, r.dst, r.wcmd, exp_data);
        end
        step();
        offer(rs[4]);
        exp_q.push_back(rs[4]);
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pp_pushpop_ready: ready=%b busy=%b, required 1/1", req_ready, busy);
        end
        step();
        offer(rs[5]);
        exp_q.push_back(rs[5]);
        vectors++;
        if (req_ready !== 1'b1 || read_id !== rs[1].src) begin
            miscompares++;
            $display("FAIL pp_after: ready=%b rid=%h, required 1/%h", req_ready, read_id, rs[1].src);
        end
        step();
        req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pp_full: ready=%b, required 0", req_ready);
        end
        while (got < 5 && cyc < 200) begin
            if (done === 1'b1) begin
                r = exp_q.pop_front();
                vectors++;
                if ({write_id, write_command, out_data} !== {r.dst, r.wcmd, exp_data}) begin
                    miscompares++;
                    $display("FAIL pp_order%0d: wid=%h wcmd=%h data=%h, required %h/%h/%h",
                             got, write_id, write_command, out_data, r.dst, r.wcmd, exp_data);
                end
                got++;
            end
            in_valid = (read_id !== 4'd0);
            in_data  = DW'($urandom);
            if (in_valid) exp_data = in_data;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (got != 5) begin
            miscompares++;
            $display("FAIL pp_timeout: completed=%0d, required 5", got);
        end
        exp_q.delete();
        step();
    endtask

    task automatic test_random();
        localparam int N = 16;
        bus_req_t cur, r;
        int       pushes = 0, got = 0, cyc = 0, stall = 0;
        bit       rd_pending = 0;
        req_valid = 1'b0;
        in_valid  = 1'b0;
        while (got < N && cyc < 3000) begin
            if (rd_pending) begin
                vectors++;
                if (done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rnd_latency: done=%b one cycle after data, required 1", done);
                end
            end
            if (done === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_unexpected_done: done=1 with nothing queued");
                end else begin
                    r = exp_q.pop_front();
                    if ({write_id, write_command, out_valid, out_data, read_id} !==
                        {r.dst, r.wcmd, (r.dst != 4'd0), exp_data, 4'd0}) begin
                        miscompares++;
                        $display("FAIL rnd_write%0d: wid=%h wcmd=%h v=%b data=%h rid=%h, required %h/%h/%b/%h/0", got,
                                 write_id, write_command, out_valid, out_data, read_id,
                                 r.dst, r.wcmd, (r.dst != 4'd0), exp_data);
                    end
                end
                got++;
            end else begin
                vectors++;
                if ({write_id, write_command, out_valid, out_data, error} !== '0) begin
                    miscompares++;
                    $display("FAIL rnd_idle_write: wid=%h wcmd=%h v=%b data=%h err=%b, required 0",
                             write_id, write_command, out_valid, out_data, error);
                end
            end
            if (read_id !== 4'd0) begin
                vectors++;
                if (exp_q.size() == 0 || {read_id, read_command} !== {exp_q[0].src, exp_q[0].rcmd}) begin
                    miscompares++;
                    $display("FAIL rnd_read: rid=%h rcmd=%h, required head of queue", read_id, read_command);
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(cur);
                pushes++;
                req_valid = 1'b0;
            end
            if (!req_valid && pushes < N && $urandom_range(1) == 1) begin
                cur = rand_req();
                offer(cur);
            end
            in_valid = 1'b0;
            rd_pending = 0;
            if (read_id !== 4'd0) begin
                if (stall >= 4 || $urandom_range(2) == 0) begin
                    in_valid   = 1'b1;
                    in_data    = DW'($urandom);
                    exp_data   = in_data;
                    rd_pending = 1;
                    stall      = 0;
                end else begin
                    stall++;
                end
            end
            step();
            cyc++;
        end
        req_valid = 1'b0;
        in_valid  = 1'b0;
        vectors++;
        if (got != N) begin
            miscompares++;
            $display("FAIL rnd_timeout: completed=%0d, required %0d", got, N);
        end
        exp_q.delete();
        step();
    endtask

`ifdef BUS_SEQUENCER_TIMEOUT_EN
    task automatic test_timeout();
        bus_req_t a = rand_req();
        bus_req_t b = rand_req();
        int       n = 0, reads = 0, dones = 0;
        in_valid = 1'b0;
        offer(a);
        step();
        offer(b);
        step();
        req_valid = 1'b0;
        while (read_id !== a.src && n < 20) begin
            step();
            n++;
        end
        while (read_id !== 4'd0 && reads < 40) begin
            reads++;
            if (done === 1'b1) dones++;
            step();
        end
        vectors++;
        if (reads != 8 || error !== 1'b1 || done !== 1'b0 || dones != 0) begin
            miscompares++;
            $display("FAIL tmo_abort: read_cycles=%0d err=%b done=%b, required 8/1/0", reads, error, done);
        end
        step();
        vectors++;
        if (error !== 1'b0 || read_id !== b.src) begin
            miscompares++;
            $display("FAIL tmo_next: err=%b rid=%h, required 0/%h", error, read_id, b.src);
        end
        repeat (7) step();
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        exp_data = in_data;
        step();
        in_valid = 1'b0;
        vectors++;
        if ({done, error, write_id, out_data} !== {1'b1, 1'b0, b.dst, exp_data}) begin
            miscompares++;
            $display("FAIL tmo_priority: done=%b err=%b wid=%h data=%h, required 1/0/%h/%h",
                     done, error, write_id, out_data, b.dst, exp_data);
        end
        step();
    endtask
`endif

    task automatic test_reset_mid();
        bus_req_t rs[3];
        int       n = 0, dones = 0, busies = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rs[i] = rand_req();
            offer(rs[i]);
            step();
        end
        req_valid = 1'b0;
        while (read_id !== rs[0].src && n < 20) begin
            step();
            n++;
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({read_id, read_command, write_id, write_command, out_data, out_valid, done, error, busy} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: rid=%h rcmd=%h busy=%b done=%b, required all 0",
                     read_id, read_command, busy, done);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) dones++;
            if (busy !== 1'b0 || read_id !== 4'd0) busies++;
            step();
        end
        vectors++;
        if (dones != 0 || busies != 0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_after: dones=%0d busy_cycles=%0d ready=%b, required 0/0/1",
                     dones, busies, req_ready);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        req_rcmd  = '0;
        req_wcmd  = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        exp_data  = '0;
        test_reset();
        test_single();
        test_dst_zero();
        test_back_to_back();
        test_push_pop();
        test_random();
`ifdef BUS_SEQUENCER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
